// File: rtl/cordic_pkg.sv
// Shared types and fixed-point constants for the CORDIC engine.
// Constants are held at 64-bit Q2.62 and truncated to the engine's F.
package cordic_pkg;

  typedef enum logic {ROTATE, VECTOR} mode_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [63:0] K    = 64'h26DD3B6A10D79699;
  localparam logic [63:0] PI   = 64'hC90FDAA22168C234;
  localparam logic [63:0] PI_2 = 64'h6487ED5110B4611A;

  // atan(2^-i) at Q2.62 from the alternating Taylor series; only ever
  // called with elaboration constants, so it folds into a constant table.
  function automatic logic [63:0] atan_lut(input int i);
    logic [63:0] acc;
    logic [63:0] term;
    int          sh;
    acc = '0;
    if (i == 0) return PI_2 >> 1;
    for (int k = 1; k < 64; k += 2) begin
      sh = 62 - k * i;
      if (sh >= 0) begin
        term = (64'd1 << sh) / 64'(k);
        if (((k >> 1) & 1) == 1) acc = acc - term;
        else                     acc = acc + term;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/cordic_engine_stage.sv
// One combinational CORDIC micro-rotation, shared by rotation and vectoring.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int W = 40
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] z_i,
  input  logic        [5:0]   shift_i,
  input  logic signed [W-1:0] atan_i,
  input  logic                mode_i,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic signed [W-1:0] z_o
);

  logic               d_pos;
  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;

  // Rotation drives z towards 0; vectoring drives y towards 0.
  assign d_pos = (mode_i == VECTOR) ? y_i[W-1] : ~z_i[W-1];
  assign xs    = x_i >>> shift_i;
  assign ys    = y_i >>> shift_i;

  assign x_o = d_pos ? x_i - ys     : x_i + ys;
  assign y_o = d_pos ? y_i + xs     : y_i - xs;
  assign z_o = d_pos ? z_i - atan_i : z_i + atan_i;

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: quadrant pre-processing, UNROLL stages per
// enabled cycle, and a held result register with valid/ready handshake.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int W      = 40,
  parameter int F      = 36,
  parameter int ITERS  = 32,
  parameter int UNROLL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] z_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic signed [W-1:0] z_o
);

  localparam int NCYC = ITERS / UNROLL;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);
  localparam logic signed [W-1:0] K_W    = W'(K    >> (62 - F));
  localparam logic signed [W-1:0] PI_W   = W'(PI   >> (62 - F));
  localparam logic signed [W-1:0] PI_2_W = W'(PI_2 >> (62 - F));

  if (W - F < 3) begin : g_bad_width
    $error("cordic_engine: W-F must be at least 3 for pi and gain headroom");
  end
  if ((ITERS % UNROLL) != 0 || ITERS > 48) begin : g_bad_iters
    $error("cordic_engine: ITERS must be a multiple of UNROLL and at most 48");
  end

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [CW-1:0]       count_q, count_d;
  logic                flip_q, flip_d, zero_q, zero_d, out_valid_q, out_valid_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [W-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic signed [W-1:0] atan_rom [64];
  logic signed [W-1:0] sx [UNROLL+1];
  logic signed [W-1:0] sy [UNROLL+1];
  logic signed [W-1:0] sz [UNROLL+1];

  for (genvar g = 0; g < 64; g++) begin : g_rom
    assign atan_rom[g] = W'(atan_lut(g) >> (62 - F));
  end

  assign sx[0] = x_q;
  assign sy[0] = y_q;
  assign sz[0] = z_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_stage
    logic [5:0] shift;
    assign shift = 6'(int'(count_q) * UNROLL + k);
    cordic_stage #(.W(W)) u_stage (
      .x_i(sx[k]), .y_i(sy[k]), .z_i(sz[k]),
      .shift_i(shift), .atan_i(atan_rom[shift]), .mode_i(mode_q),
      .x_o(sx[k+1]), .y_o(sy[k+1]), .z_o(sz[k+1])
    );
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign x_o       = xo_q;
  assign y_o       = yo_q;
  assign z_o       = zo_q;

  always_comb begin
    // NOTE: every variable gets a hold default first, so no path infers a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    count_d     = count_q;
    flip_d      = flip_q;
    zero_d      = zero_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    xo_d        = xo_q;
    yo_d        = yo_q;
    zo_d        = zo_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        mode_d  = mode_t'(mode);
        count_d = '0;
        state_d = BUSY;
        if (mode_t'(mode) == ROTATE) begin
          x_d    = K_W;
          y_d    = '0;
          zero_d = 1'b0;
          if (z_i > PI_2_W) begin
            z_d = PI_W - z_i;  flip_d = 1'b1;
          end else if (z_i < -PI_2_W) begin
            z_d = -PI_W - z_i; flip_d = 1'b1;
          end else begin
            z_d = z_i;         flip_d = 1'b0;
          end
        end else begin
          flip_d = 1'b0;
          zero_d = (x_i == '0) && (y_i == '0);
          if (x_i[W-1]) begin
            x_d = -x_i;
            y_d = -y_i;
            z_d = y_i[W-1] ? -PI_W : PI_W;
          end else begin
            x_d = x_i;
            y_d = y_i;
            z_d = '0;
          end
        end
      end
      BUSY: begin
        x_d     = sx[UNROLL];
        y_d     = sy[UNROLL];
        z_d     = sz[UNROLL];
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (mode_q == ROTATE) begin
            xo_d = flip_q ? -sx[UNROLL] : sx[UNROLL];
            yo_d = sy[UNROLL];
            zo_d = sz[UNROLL];
          end else begin
            xo_d = zero_q ? '0 : sx[UNROLL];
            yo_d = zero_q ? '0 : sy[UNROLL];
            zo_d = zero_q ? '0 : sz[UNROLL];
          end
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is asynchronous and active-high; it wins over clk_en so an
  // in-flight result is dropped immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state_q <= IDLE;
    else if (clk_en) state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= ROTATE;
      count_q     <= '0;
      flip_q      <= 1'b0;
      zero_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      xo_q        <= '0;
      yo_q        <= '0;
      zo_q        <= '0;
      out_valid_q <= 1'b0;
    end else if (clk_en) begin
      mode_q      <= mode_d;
      count_q     <= count_d;
      flip_q      <= flip_d;
      zero_q      <= zero_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
      zo_q        <= zo_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine: real-valued trig model feeding a
// scoreboard, plus latency, backpressure, clock-enable and reset scenarios.
module tb_cordic_engine;

  localparam int  W      = 40;
  localparam int  F      = 36;
  localparam int  ITERS  = 32;
  localparam int  UNROLL = 4;
  localparam int  LAT    = ITERS / UNROLL;
  localparam int  TOL    = 256;
  localparam real SCALE  = 68719476736.0;
  localparam real PI_R   = 3.14159265358979323846;
  localparam real AN_R   = 1.6467602581210656;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clk_en = 1'b1;
  logic                in_valid = 1'b0;
  logic                mode = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] x_i = '0;
  logic signed [W-1:0] y_i = '0;
  logic signed [W-1:0] z_i = '0;
  logic                in_ready;
  logic                out_valid;
  logic signed [W-1:0] x_o;
  logic signed [W-1:0] y_o;
  logic signed [W-1:0] z_o;

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;
    bit                  exact;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  cordic_engine #(.W(W), .F(F), .ITERS(ITERS), .UNROLL(UNROLL)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_o(x_o), .y_o(y_o), .z_o(z_o)
  );

  always #5 clk = ~clk;

  function automatic logic signed [W-1:0] to_fx(real r);
    return W'(longint'(r * SCALE));
  endfunction

  function automatic exp_t model(bit vec, real xr, real yr, real zr);
    exp_t m;
    m.exact = 1'b0;
    if (!vec) begin
      m.x = to_fx($cos(zr));
      m.y = to_fx($sin(zr));
      m.z = '0;
    end else if (xr == 0.0 && yr == 0.0) begin
      m.x = '0; m.y = '0; m.z = '0;
      m.exact = 1'b1;
    end else begin
      m.x = to_fx(AN_R * $sqrt(xr * xr + yr * yr));
      m.y = '0;
      m.z = to_fx($atan2(yr, xr));
    end
    return m;
  endfunction

  // Returns just after the accepting clock edge, with in_valid still high.
  task automatic send(bit vec, real xr, real yr, real zr);
    int waited;
    @(negedge clk);
    sb.push_back(model(vec, xr, yr, zr));
    mode = vec;
    x_i = to_fx(xr);
    y_i = to_fx(yr);
    z_i = to_fx(zr);
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_ready: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic wait_valid(input bit keep_valid, output int cyc);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (out_valid !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL wait_valid: out_valid=%b required 1 within 100 cycles", out_valid);
    end
  endtask

  task automatic drain(string tag);
    exp_t                e;
    logic signed [W-1:0] got  [3];
    logic signed [W-1:0] want [3];
    string               fld  [3];
    longint              diff;
    bit                  bad;
    fld = '{"x", "y", "z"};
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: result with empty scoreboard, got x=%0d required none", tag, x_o);
    end else begin
      e    = sb.pop_front();
      got  = '{x_o, y_o, z_o};
      want = '{e.x, e.y, e.z};
      for (int k = 0; k < 3; k++) begin
        diff = longint'(got[k]) - longint'(want[k]);
        bad  = e.exact ? (diff != 0) : (diff > TOL || diff < -TOL);
        vectors++;
        if (bad) begin
          miscompares++;
          $display("FAIL %s.%s: got %0d required %0d (tol %0d)",
                   tag, fld[k], got[k], want[k], e.exact ? 0 : TOL);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s.release: out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
    end
  endtask

  task automatic run_one(string tag, bit vec, real xr, real yr, real zr);
    int cyc;
    send(vec, xr, yr, zr);
    wait_valid(1'b0, cyc);
    vectors++;
    if (cyc !== LAT) begin
      miscompares++;
      $display("FAIL %s.latency: got %0d cycles required %0d", tag, cyc, LAT);
    end
    drain(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    vectors++;
    if (x_o !== '0 || y_o !== '0 || z_o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0d/%0d/%0d required 0/0/0", x_o, y_o, z_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    run_one("rot_0",       1'b0, 0.0, 0.0, 0.0);
    run_one("rot_3pi4",    1'b0, 0.0, 0.0, 3.0 * PI_R / 4.0);
    run_one("rot_m_pi2",   1'b0, 0.0, 0.0, -PI_R / 2.0);
    run_one("rot_pi2",     1'b0, 0.0, 0.0, PI_R / 2.0);
    run_one("rot_1",       1'b0, 0.0, 0.0, 1.0);
    run_one("rot_m2p5",    1'b0, 0.0, 0.0, -2.5);
  endtask

  task automatic test_vectoring();
    run_one("vec_45",      1'b1, 0.5, 0.5, 0.0);
    run_one("vec_m1_0",    1'b1, -1.0, 0.0, 0.0);
    run_one("vec_zero",    1'b1, 0.0, 0.0, 0.0);
    run_one("vec_q4",      1'b1, 0.3, -0.8, 0.0);
    run_one("vec_q3",      1'b1, -0.6, -0.4, 0.0);
    run_one("vec_0_1",     1'b1, 0.0, 1.0, 0.0);
  endtask

  task automatic test_backpressure();
    int                  cyc;
    bit                  bad;
    logic signed [W-1:0] sx, sy, sz;
    send(1'b1, 0.5, 0.5, 0.0);
    wait_valid(1'b1, cyc);
    sx = x_o; sy = y_o; sz = z_o;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          x_o !== sx || y_o !== sy || z_o !== sz) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL bp_hold: out_valid=%b in_ready=%b x=%0d required 1/0/%0d held",
               out_valid, in_ready, x_o, sx);
    end
    in_valid = 1'b0;
    drain("bp_result");
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_second_accept: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_clk_en();
    int cyc;
    send(1'b0, 0.0, 0.0, 3.0 * PI_R / 4.0);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) break;
      clk_en = ~clk_en;
      cyc++;
    end
    clk_en = 1'b1;
    vectors++;
    if (cyc !== 2 * LAT) begin
      miscompares++;
      $display("FAIL clken_latency: got %0d cycles required %0d", cyc, 2 * LAT);
    end
    drain("clken_result");
  endtask

  task automatic test_reset_mid_busy();
    bit spurious;
    send(1'b0, 0.0, 0.0, 1.0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || x_o !== '0 || y_o !== '0 || z_o !== '0) begin
      miscompares++;
      $display("FAIL rst_busy_outputs: out_valid=%b x=%0d y=%0d z=%0d required all 0",
               out_valid, x_o, y_o, z_o);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_busy_ready: in_ready=%b required 1", in_ready);
    end
    spurious = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin
      miscompares++;
      $display("FAIL rst_busy_spurious: out_valid seen 1 required 0");
    end
    run_one("rst_busy_next", 1'b0, 0.0, 0.0, 0.5);
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_backpressure();
    test_clk_en();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Parametrised iterative CORDIC engine for the fixed-point maths peripheral.
- Rotation mode returns cos and sin together. Vectoring mode returns gain-scaled magnitude and atan2.
- Valid/ready handshakes on input and output. Configurable total iterations and iterations per clock.
- Sits behind the peripheral register interface; clk_en comes from the host-side clock gate.

Parameters:
- W, 40, total signed fixed-point width (Q(W-F).F two's complement)
- F, 36, fractional bits
- ITERS, 32, total CORDIC iterations; multiple of UNROLL, ≤ 48
- UNROLL, 4, combinational iterations per enabled cycle

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clk_en  in  1  global enable; low freezes all state
- in_valid  in  1  request valid
- in_ready  out  1  engine can accept a request
- mode  in  1  0 = rotation, 1 = vectoring; sampled on accept
- x_i  in  W  vectoring x, |x| ≤ 1.0; ignored in rotation
- y_i  in  W  vectoring y, |y| ≤ 1.0; ignored in rotation
- z_i  in  W  rotation angle in rad, [-π, π]; ignored in vectoring
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- x_o  out  W  rotation: cos; vectoring: An·sqrt(x²+y²), An ≈ 1.646760258
- y_o  out  W  rotation: sin; vectoring: residual y
- z_o  out  W  rotation: residual angle; vectoring: atan2(y,x)

Behaviour:
- Reset (asynchronous): state IDLE; out_valid = 0; x_o = y_o = z_o = 0; iteration counter and datapath registers = 0.
- All registered updates occur only when clk_en = 1. With clk_en low, outputs and state hold.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). It is combinational from state only.
- IDLE: on in_valid & clk_en, latch mode, apply pre-processing, clear count, go to BUSY.
- BUSY: each enabled cycle runs UNROLL iterations, i = count·UNROLL … count·UNROLL+UNROLL-1.
  - On the final cycle (count == ITERS/UNROLL-1), register x_o/y_o/z_o, set out_valid, go to DONE.
- Latency: out_valid rises exactly ITERS/UNROLL enabled cycles after the accept edge. Default is 8.
- DONE: out_valid and outputs are held stable until out_ready & clk_en, then clear out_valid and go to IDLE.
  - No accept in the same cycle; minimum issue interval is ITERS/UNROLL+2 cycles.
- Rotation pre-processing:
  - init x = K, y = 0.
  - If z_i > π/2: z = π − z_i, flip = 1.
  - If z_i < −π/2: z = −π − z_i, flip = 1.
  - Otherwise z = z_i, flip = 0. Exactly ±π/2 gets no reduction.
- Rotation iteration: d = (z ≥ 0) ? +1 : −1.
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan(2^−i)
- Rotation result: x_o = flip ? −x : x; y_o = y (sine is unchanged by the reduction).
- Vectoring pre-processing:
  - If x_i < 0: x = −x_i, y = −y_i, z = (y_i ≥ 0) ? π : −π.
  - Otherwise x = x_i, y = y_i, z = 0.
  - If x_i == 0 and y_i == 0, set zero flag.
- Vectoring iteration: d = (y < 0) ? +1 : −1, same update equations.
- Vectoring result: x_o = x, y_o = y, z_o = z. If the zero flag is set, force all three outputs to 0.
- Arithmetic:
  - Arithmetic right shifts; wrap-around two's complement add/sub at width W. No saturation.
  - W−F ≥ 3 is required for the ±π and 2.33 magnitude headroom; enforce with an elaboration-time assertion.
- Inputs outside the stated ranges produce unspecified results, but the FSM and handshake must stay correct.
- Reset mid-BUSY or mid-DONE: the result is discarded, out_valid drops immediately, and no later spurious out_valid occurs.

Decomposition:
- Package cordic_pkg holds:
  - mode_t enum (ROTATE, VECTOR) and state_t enum (IDLE, BUSY, DONE)
  - fixed-point constants at 64-bit F=62, truncated to F: K = 0.6072529350, PI, PI_2
  - function atan_lut(i) returning atan(2^−i) for i < 48
- Sub-module cordic_stage: one combinational iteration (x, y, z, shift i, atan value, mode) → (x', y', z').
  - Instantiated UNROLL times via generate.
- Top cordic_engine holds the FSM, counter, pre/post-processing and output registers.

Test Plan:
- Accuracy tolerance for all results: |err| ≤ 2^(F−28), i.e. 256 LSB at F=36.
- Rotation z_i = 0: after 8 cycles, x_o = 2^36 (1.0) and y_o = 0.
- Rotation z_i = 3π/4 (exercises the flip path):
  - x_o = −0.70710678·2^36
  - y_o = +0.70710678·2^36
- Rotation z_i = −π/2: x_o = 0, y_o = −2^36.
- Vectoring x_i = y_i = 0.5·2^36: z_o = π/4·2^36, x_o = 1.16443·2^36.
- Vectoring x_i = −1.0, y_i = 0: z_o = +π (within tolerance), x_o = 1.64676·2^36.
- Vectoring x_i = y_i = 0: all outputs exactly 0.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles with in_valid = 1: out_valid and outputs stay constant, in_ready = 0, and no second accept occurs.
  - After the out_ready pulse, in_ready = 1 on the next cycle.
- clk_en toggled 1/0 every cycle: latency doubles to 16 cycles and results are identical.
- Reset asserted 3 cycles into BUSY: out_valid and outputs = 0 at once, in_ready = 1 after release, and the next request completes correctly.
